// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its LSU result buffer.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering LSU writeback entries; count-based full/empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and buffered LSU results onto the single register-file write port,
// with starvation relief for loads and a per-register load-busy scoreboard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_hold,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  wb_entry_t             lsu_entry;
  wb_entry_t             alu_entry;
  wb_entry_t             fifo_head;
  wb_entry_t             sel;
  wb_src_e               src;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [STARVE_W-1:0]   starve_next;
  logic                  hold_next;
  logic [NUM_REGS-1:0]   busy_next;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign lsu_ready = rst_n && !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready;
  assign fifo_pop  = (src == SRC_FIFO);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lsu_entry),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An ALU result arriving under alu_hold is a protocol violation and is dropped.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    src = SRC_IDLE;
    sel = alu_entry;
    if (alu_hold && !fifo_empty) begin
      src = SRC_FIFO;
      sel = fifo_head;
    end else if (alu_valid && !alu_hold) begin
      src = SRC_ALU;
      sel = alu_entry;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
      sel = fifo_head;
    end
  end

  always_comb begin
    starve_next = starve_cnt;
    hold_next   = 1'b0;
    if (fifo_empty || fifo_pop) begin
      starve_next = '0;
    end else if (src == SRC_ALU) begin
      if (starve_cnt == STARVE_W'(STARVE_MAX - 1)) begin
        starve_next = '0;
        hold_next   = 1'b1;
      end else begin
        starve_next = starve_cnt + STARVE_W'(1);
      end
    end
  end

  // Clear comes first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (fifo_pop && (sel.rd != '0)) busy_next[sel.rd] = 1'b0;
    if (ld_issue && (ld_rd != '0))  busy_next[ld_rd]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_hold   <= 1'b0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      rf_we      <= (src != SRC_IDLE) && (sel.rd != '0);
      alu_hold   <= hold_next;
      starve_cnt <= starve_next;
      busy       <= busy_next;
      if (src != SRC_IDLE) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the rv32 core: merges single-cycle ALU results and variable-latency LSU load results onto the register file's single write port (`we`, `w_addr`, `w_data`), which it drives. LSU results are buffered in a small FIFO. A per-register busy scoreboard is kept for the issue-stage load-use interlock. Sits between execute/LSU and the register file; the register file's same-cycle write bypass covers the write cycle.

## Interface
- `XLEN`, 32, data width
- `FIFO_DEPTH`, 2, LSU result buffer entries (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive cycles a non-empty FIFO may lose arbitration before `alu_hold` fires (≥1)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle (no ready; always consumed)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `alu_hold`  out  1  registered; upstream must present `alu_valid`=0 in every cycle it is high
- `lsu_valid`  in  1  load result offered
- `lsu_ready`  out  1  FIFO can accept; transfer when `lsu_valid & lsu_ready`
- `lsu_rd`  in  5  load destination
- `lsu_data`  in  XLEN  load data
- `ld_issue`  in  1  a load to `ld_rd` issued this cycle
- `ld_rd`  in  5  destination of issuing load
- `busy`  out  32  bit i set while a load to xi is outstanding; bit 0 always 0
- `rf_we`, `rf_waddr` (5), `rf_wdata` (XLEN)  out  registered register-file write port

## Operation
- LSU results always enter the FIFO; `lsu_ready = !full` (0 while `rst_n` low). No push when full, even if popping that cycle.
- Arbitration each cycle, in priority order: `alu_hold`=1 with FIFO non-empty → pop head; else `alu_valid` → ALU; else FIFO non-empty → pop head; else idle.
- Selected result registered to `rf_we/rf_waddr/rf_wdata` next edge. rd=0 results are consumed (FIFO popped) but give `rf_we`=0.
- `alu_valid` high while `alu_hold` high is a protocol violation (bench assertion); the ALU result is dropped.
- Starvation counter `starve_cnt`: +1 each cycle the FIFO is non-empty and the ALU wins; cleared on pop or when empty. On reaching `STARVE_MAX`, `alu_hold` is 1 for exactly the next cycle and the counter clears.
- Scoreboard: `ld_issue` with `ld_rd`≠0 sets `busy[ld_rd]`; a popped FIFO entry clears `busy[rd]`. A simultaneous set and clear of the same bit → set wins. ALU writes do not touch `busy`. The issue stage guarantees no ALU write to a busy rd (WAW), so no ordering check is made here.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `alu_hold`=0, `busy`=0, FIFO empty, `starve_cnt`=0. Reset mid-operation discards FIFO contents and all busy bits.
- ALU latency: `alu_valid` at cycle N → `rf_we` at N+1.
- LSU latency: accepted at N → earliest `rf_we` at N+2. `busy` clears in the same edge that registers `rf_we`.
- `lsu_ready` is combinational from FIFO count. It rises the cycle after a pop from full.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full/empty use a count (or an extra pointer bit).

## Structure
- Shared package `wb_pkg`: `XLEN`, `REG_ADDR_W`=5, `NUM_REGS`=32, writeback-entry struct {rd, data}.
- Sub-module `wb_fifo`: synchronous FIFO with push/pop/full/empty/head and the same `clk`/`rst_n`.
- Arbiter, starvation counter and scoreboard live in `wb_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with inputs active → `rf_we`=0, `busy`=0, `lsu_ready`=0. Release → `lsu_ready`=1.
- ALU only: `alu_valid`, rd=5, data=0x1234 at N → at N+1 `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234. Repeat with rd=0 → `rf_we`=0.
- Load path: `ld_issue` rd=7 → `busy[7]`=1 next cycle. LSU rd=7, data=0xDEADBEEF accepted at N with no ALU traffic → `rf_we` at N+2 with that data; `busy[7]`=0 from N+2.
- Contention/full: ALU valid every cycle, LSU pushes rd=3 then rd=4 → FIFO full, `lsu_ready`=0. After 4 ALU wins `alu_hold`=1 for 1 cycle, rd=3 written next, `lsu_ready` back to 1.
- Simultaneous set/clear: pop of rd=9 on the same cycle as `ld_issue` rd=9 → `busy[9]` stays 1; `ld_issue` rd=0 → `busy[0]` stays 0.
- Reset mid-operation with FIFO holding 2 entries and `busy[3]`=1 → no further `rf_we`, `busy`=0, FIFO empty.
